// File: rtl/avl_st_2_avl_st_video.sv
`default_nettype none
// ============================================================================
// Module   : avl_st_2_avl_st_video
// Function : repacks a 32-bit byte stream into 24-bit Avalon-ST Video pixels,
//            prefixed by a video-data header (and, with AVL_VIDEO_CTRL_PKT_EN
//            defined, a frame-size control packet before every video packet).
// Revision : 1.0 - initial release
// ============================================================================
module avl_st_2_avl_st_video #(
   parameter int FRAME_WIDTH  = 800,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_avl_st_data,
   input  logic        in_avl_st_valid,
   input  logic        in_avl_st_startofpacket,
   input  logic        in_avl_st_endofpacket,
   output logic        in_avl_st_ready,
   output logic [23:0] out_avl_st_data,
   output logic        out_avl_st_valid,
   output logic        out_avl_st_startofpacket,
   output logic        out_avl_st_endofpacket,
   input  logic        out_avl_st_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CTRL   = 2'd1,
      HDR    = 2'd2,
      PIXELS = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d, cnt_base;
   logic [63:0] sr_q, sr_d, sr_base, ins_mask;
   logic [6:0]  ins_sh;
   logic        eop_q, eop_d;
   logic        out_hs, in_hs;
   logic        out_valid_d, out_sop_d, out_eop_d;
   logic [23:0] out_data_d;

`ifdef AVL_VIDEO_CTRL_PKT_EN
   localparam logic [15:0] c_frame_w = 16'(FRAME_WIDTH);
   localparam logic [15:0] c_frame_h = 16'(FRAME_HEIGHT);

   logic [1:0] beat_q, beat_d;

   // Frame dimensions are spread one nibble per symbol, as Avalon-ST Video expects
   function automatic logic [23:0] ctrl_beat(input logic [1:0] idx);
      logic [23:0] d;
      case (idx)
         2'd0:    d = 24'h00000F;
         2'd1:    d = {4'h0, c_frame_w[7:4],  4'h0, c_frame_w[11:8],  4'h0, c_frame_w[15:12]};
         2'd2:    d = {4'h0, c_frame_h[11:8], 4'h0, c_frame_h[15:12], 4'h0, c_frame_w[3:0]};
         default: d = {8'h00, 4'h0, c_frame_h[3:0], 4'h0, c_frame_h[7:4]};
      endcase
      return d;
   endfunction
`else
   logic unused_frame_cfg;
   assign unused_frame_cfg = ^{16'(FRAME_WIDTH), 16'(FRAME_HEIGHT)};
`endif

   assign out_hs = out_avl_st_valid && out_avl_st_ready;
   assign in_hs  = in_avl_st_valid && in_avl_st_ready;

   // The SOP word is held back in IDLE so it becomes the first PIXELS word
   always_comb begin
      in_avl_st_ready = 1'b0;
      case (state_q)
         IDLE:    in_avl_st_ready = !(in_avl_st_valid && in_avl_st_startofpacket);
         PIXELS:  in_avl_st_ready = (cnt_q <= 4'd4) && !eop_q;
         default: in_avl_st_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      eop_d    = eop_q;
      cnt_base = cnt_q;
      sr_base  = sr_q;
      ins_sh   = '0;
      ins_mask = '0;
`ifdef AVL_VIDEO_CTRL_PKT_EN
      beat_d   = beat_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_avl_st_valid && in_avl_st_startofpacket) begin
`ifdef AVL_VIDEO_CTRL_PKT_EN
               state_d = CTRL;
               beat_d  = 2'd0;
`else
               state_d = HDR;
`endif
            end
         end
`ifdef AVL_VIDEO_CTRL_PKT_EN
         CTRL: begin
            if (out_hs) begin
               if (beat_q == 2'd3) state_d = HDR;
               else                beat_d  = beat_q + 2'd1;
            end
         end
`endif
         HDR: begin
            if (out_hs) begin
               if (out_avl_st_endofpacket) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  sr_d    = '0;
                  eop_d   = 1'b0;
               end else begin
                  state_d = PIXELS;
               end
            end
         end
         PIXELS: begin
            if (out_hs && out_avl_st_endofpacket) begin
               state_d = IDLE;
               cnt_d   = '0;
               sr_d    = '0;
               eop_d   = 1'b0;
            end else begin
               // Emit first, then append the new word above what remains
               if (out_hs) begin
                  cnt_base = cnt_q - 4'd3;
                  sr_base  = {24'h0, sr_q[63:24]};
               end
               ins_sh   = {cnt_base[3:0], 3'b000};
               ins_mask = {32'h0, 32'hFFFF_FFFF} << ins_sh;
               cnt_d    = cnt_base;
               sr_d     = sr_base;
               if (in_hs) begin
                  sr_d  = (sr_base & ~ins_mask) | ({32'h0, in_avl_st_data} << ins_sh);
                  cnt_d = cnt_base + 4'd4;
                  eop_d = eop_q | in_avl_st_endofpacket;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_data_d  = '0;
      case (state_d)
`ifdef AVL_VIDEO_CTRL_PKT_EN
         CTRL: begin
            out_valid_d = 1'b1;
            out_data_d  = ctrl_beat(beat_d);
            out_sop_d   = (beat_d == 2'd0);
            out_eop_d   = (beat_d == 2'd3);
         end
`endif
         HDR: begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_eop_d   = eop_d && (cnt_d < 4'd3);
         end
         PIXELS: begin
            if (cnt_d >= 4'd3) begin
               out_valid_d = 1'b1;
               out_data_d  = {sr_d[7:0], sr_d[15:8], sr_d[23:16]};
               out_eop_d   = eop_d && (cnt_d < 4'd6);
            end
         end
         default: out_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q                  <= IDLE;
         cnt_q                    <= '0;
         sr_q                     <= '0;
         eop_q                    <= 1'b0;
         out_avl_st_valid         <= 1'b0;
         out_avl_st_startofpacket <= 1'b0;
         out_avl_st_endofpacket   <= 1'b0;
         out_avl_st_data          <= '0;
`ifdef AVL_VIDEO_CTRL_PKT_EN
         beat_q                   <= '0;
`endif
      end else begin
         state_q                  <= state_d;
         cnt_q                    <= cnt_d;
         sr_q                     <= sr_d;
         eop_q                    <= eop_d;
         out_avl_st_valid         <= out_valid_d;
         out_avl_st_startofpacket <= out_sop_d;
         out_avl_st_endofpacket   <= out_eop_d;
         out_avl_st_data          <= out_data_d;
`ifdef AVL_VIDEO_CTRL_PKT_EN
         beat_q                   <= beat_d;
`endif
      end
   end

endmodule
`default_nettype wire
